// File: rtl/float_stream_tx_if.sv
// float_stream_tx_if: float_24_8 vld/rdy/fst stream between a producer and a stage tap/data input
interface float_stream_tx_if;
  logic [31:0] tap_out;
  logic        tap_out_fst;
  logic        tap_out_vld;
  logic        tap_out_rdy;
  modport master (output tap_out, output tap_out_fst, output tap_out_vld, input tap_out_rdy);
  modport slave  (input tap_out, input tap_out_fst, input tap_out_vld, output tap_out_rdy);
endinterface

// File: rtl/float_stream_tx.sv
// float_stream_tx: replays a preloaded word buffer as repeated fst-marked frames; optional abort input under FLOAT_STREAM_TX_ABORT_EN
module float_stream_tx #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [31:0]     wr_data,
  input  logic            start,
  input  logic [AW:0]     frame_len,
  input  logic [7:0]      repeat_cnt,
`ifdef FLOAT_STREAM_TX_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  float_stream_tx_if.master tap
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  state_t      state;
  logic [31:0] mem [DEPTH];
  logic [AW:0] len;
  logic [AW:0] rd_ptr;
  logic [7:0]  reps;
  logic [7:0]  frame_cnt;
  logic [AW:0] clamp;
  logic        ab;
`ifdef FLOAT_STREAM_TX_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif
  assign clamp = frame_len > DMAX ? DMAX : frame_len;
  assign busy  = state != IDLE;
  // buffer writes are only accepted while idle so a running frame never changes
  always_ff @(posedge clk)
    if (wr_en && state == IDLE) mem[wr_addr] <= wr_data;
  // control FSM with registered stream outputs; a zero-length run holds DONE one extra cycle so done lands at start+2
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      tap.tap_out     <= '0;
      tap.tap_out_fst <= 1'b0;
      tap.tap_out_vld <= 1'b0;
      done            <= 1'b0;
      len             <= '0;
      reps            <= '0;
      rd_ptr          <= '0;
      frame_cnt       <= '0;
    end else if (ab && (state == LOAD || state == RUN)) begin
      state           <= IDLE;
      tap.tap_out_vld <= 1'b0;
      tap.tap_out_fst <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          len   <= clamp;
          reps  <= repeat_cnt;
          state <= clamp == '0 ? DONE : LOAD;
        end
        LOAD: begin
          tap.tap_out     <= mem[0];
          tap.tap_out_fst <= 1'b1;
          tap.tap_out_vld <= 1'b1;
          rd_ptr          <= ONE;
          frame_cnt       <= '0;
          state           <= RUN;
        end
        RUN: if (tap.tap_out_vld && tap.tap_out_rdy) begin
          if (rd_ptr < len) begin
            tap.tap_out     <= mem[rd_ptr[AW-1:0]];
            tap.tap_out_fst <= 1'b0;
            rd_ptr          <= rd_ptr + ONE;
          end else if (frame_cnt < reps) begin
            tap.tap_out     <= mem[0];
            tap.tap_out_fst <= 1'b1;
            rd_ptr          <= ONE;
            frame_cnt       <= frame_cnt + 8'd1;
          end else begin
            tap.tap_out_vld <= 1'b0;
            tap.tap_out_fst <= 1'b0;
            done            <= 1'b1;
            state           <= DONE;
          end
        end
        default: begin
          done  <= !done;
          state <= done ? IDLE : DONE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_float_stream_tx.sv
// tb_float_stream_tx: scoreboard bench for float_stream_tx (directed frames, backpressure, boundaries, reset, abort)
module tb_float_stream_tx;
  logic        clk = 0;
  logic        reset = 0;
  logic        wr_en = 0;
  logic [5:0]  wr_addr = 0;
  logic [31:0] wr_data = 0;
  logic        start = 0;
  logic [6:0]  frame_len = 0;
  logic [7:0]  repeat_cnt = 0;
  logic        busy, done;
`ifdef FLOAT_STREAM_TX_ABORT_EN
  logic        abort = 0;
`endif
  int          checks = 0, failures = 0, beats = 0, dones = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model [64];
  logic        held = 0;
  logic [32:0] prev = 0;

  float_stream_tx_if tap();
  float_stream_tx #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .frame_len(frame_len), .repeat_cnt(repeat_cnt),
`ifdef FLOAT_STREAM_TX_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .tap(tap.master));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) dones++;
    if (reset && tap.tap_out_vld) begin
      if (held) chk("stable_hold", {31'd0, tap.tap_out_fst, tap.tap_out}, {31'd0, prev});
      if (tap.tap_out_rdy) begin
        held = 0;
        beats++;
        if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
        else chk("beat", {31'd0, tap.tap_out_fst, tap.tap_out}, {31'd0, exp_q.pop_front()});
      end else begin
        held = 1;
        prev = {tap.tap_out_fst, tap.tap_out};
      end
    end else held = 0;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_mem(input int a, input logic [31:0] d);
    wr_en = 1; wr_addr = 6'(a); wr_data = d; model[a] = d;
    step();
    wr_en = 0;
  endtask

  task automatic push_frames(input int n, input int r);
    for (int k = 0; k <= r; k++)
      for (int i = 0; i < n; i++) exp_q.push_back({i == 0, model[i]});
  endtask

  task automatic pulse_start(input int n, input int r);
    start = 1; frame_len = 7'(n); repeat_cnt = 8'(r);
    step();
    start = 0;
  endtask

  task automatic wait_done(input int max, input bit tog);
    bit seen = 0;
    for (int c = 0; c < max && !seen; c++) begin
      if (tog) tap.tap_out_rdy = ~tap.tap_out_rdy;
      step();
      seen = done;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    tap.tap_out_rdy = 1;
    step();
  endtask

  initial begin
    int b0, d0;
    tap.tap_out_rdy = 1;
    step(); step();
    chk("rst_vld", {63'd0, tap.tap_out_vld}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_data", {32'd0, tap.tap_out}, 64'd0);
    reset = 1;
    step();
    // single frame with exact latency
    write_mem(0, 32'h3F80_0000); write_mem(1, 32'h4000_0000);
    write_mem(2, 32'h4040_0000); write_mem(3, 32'h4080_0000);
    push_frames(4, 0);
    b0 = beats;
    pulse_start(4, 0);
    chk("t1_busy_T1", {63'd0, busy}, 64'd1);
    chk("t1_vld_T1", {63'd0, tap.tap_out_vld}, 64'd0);
    step();
    chk("t1_vld_T2", {63'd0, tap.tap_out_vld}, 64'd1);
    chk("t1_first", {32'd0, tap.tap_out}, 64'h3F80_0000);
    step(); step(); step();
    chk("t1_last", {32'd0, tap.tap_out}, 64'h4080_0000);
    step();
    chk("t1_done", {62'd0, done, tap.tap_out_vld}, 64'd2);
    chk("t1_busy_at_done", {63'd0, busy}, 64'd1);
    step();
    chk("t1_idle", {62'd0, done, busy}, 64'd0);
    chk("t1_beats", 64'(beats - b0), 64'd4);
    // repeats with toggling ready
    write_mem(0, 32'h4120_0000); write_mem(1, 32'h4130_0000); write_mem(2, 32'h4140_0000);
    push_frames(3, 2);
    b0 = beats; d0 = dones;
    pulse_start(3, 2);
    wait_done(100, 1);
    chk("t2_beats", 64'(beats - b0), 64'd9);
    chk("t2_dones", 64'(dones - d0), 64'd1);
    // zero length
    b0 = beats;
    pulse_start(0, 0);
    chk("t3_done_T1", {63'd0, done}, 64'd0);
    step();
    chk("t3_done_T2", {62'd0, done, tap.tap_out_vld}, 64'd2);
    step();
    chk("t3_idle", {62'd0, done, busy}, 64'd0);
    chk("t3_beats", 64'(beats - b0), 64'd0);
    // clamped and full depth
    for (int i = 0; i < 64; i++) write_mem(i, 32'hA500_0000 | 32'(i * 3));
    push_frames(64, 0);
    b0 = beats;
    pulse_start(69, 0);
    wait_done(200, 0);
    chk("t4_clamp_beats", 64'(beats - b0), 64'd64);
    push_frames(64, 0);
    b0 = beats;
    pulse_start(64, 0);
    wait_done(200, 0);
    chk("t5_full_beats", 64'(beats - b0), 64'd64);
    // start and write ignored mid-run
    push_frames(4, 0);
    b0 = beats;
    pulse_start(4, 0);
    step(); step();
    start = 1; frame_len = 7'd2; wr_en = 1; wr_addr = 0; wr_data = 32'hDEAD_BEEF;
    step();
    start = 0; wr_en = 0;
    wait_done(50, 0);
    chk("t6_beats", 64'(beats - b0), 64'd4);
    push_frames(1, 0);
    pulse_start(1, 0);
    wait_done(50, 0);
    // reset mid-run
    push_frames(16, 0);
    d0 = dones;
    pulse_start(16, 0);
    step(); step(); step();
    reset = 0;
    step();
    chk("t7_rst", {61'd0, tap.tap_out_vld, busy, done}, 64'd0);
    exp_q.delete();
    reset = 1;
    step();
    chk("t7_no_done", 64'(dones - d0), 64'd0);
    push_frames(2, 0);
    b0 = beats;
    pulse_start(2, 0);
    wait_done(50, 0);
    chk("t7_restart_beats", 64'(beats - b0), 64'd2);
`ifdef FLOAT_STREAM_TX_ABORT_EN
    for (int i = 0; i < 5; i++) exp_q.push_back({i == 0, model[i]});
    b0 = beats; d0 = dones;
    pulse_start(16, 0);
    for (int i = 0; i < 5; i++) step();
    abort = 1;
    step();
    abort = 0;
    chk("t8_abort", {61'd0, tap.tap_out_vld, busy, done}, 64'd0);
    step(); step();
    chk("t8_no_done", 64'(dones - d0), 64'd0);
    chk("t8_beats", 64'(beats - b0), 64'd5);
`endif
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/float_stream_tx.md
# float_stream_tx

Stream transmitter that drives a float_24_8 vld/rdy/fst stream into a network stage's tap or data input (the producer end of the stage stream protocol). Software or the testbench preloads a local word buffer. A start pulse then replays the first frame_len words as one frame, with fst on the first word, and repeats the frame repeat_cnt+1 times. It sits in front of a stage block's tap_in/st_data port.

## Interface
Parameters:
- DEPTH, 64: buffer depth in words.
- AW, 6: address width, equal to log2(DEPTH).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address.
- wr_data  in  32  float_24_8 word to write.
- start  in  1  one-cycle start pulse.
- frame_len  in  AW+1  words per frame, 0..DEPTH; sampled on start.
- repeat_cnt  in  8  extra frame repetitions; sampled on start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last word of the last frame is accepted.
- tap_out  out  32  float_24_8 data.
- tap_out_fst  out  1  first word of a frame.
- tap_out_vld  out  1  data valid.
- tap_out_rdy  in  1  downstream ready.

## Operation
- State machine states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - wr_en writes mem[wr_addr].
  - start latches len = min(frame_len, DEPTH) and reps = repeat_cnt.
  - If len==0, go to DONE. Otherwise go to LOAD.
- LOAD: output register ← mem[0], fst=1, vld=1, rd_ptr=1, frame_cnt=0. Go to RUN.
- RUN, on a transfer (vld && rdy):
  - If rd_ptr < len: output ← mem[rd_ptr], fst=0, rd_ptr++.
  - Else if frame_cnt < reps: output ← mem[0], fst=1, rd_ptr=1, frame_cnt++.
  - Else: vld=0, go to DONE.
- RUN, no transfer: tap_out, tap_out_fst and tap_out_vld hold stable. No change while vld && !rdy.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- busy = (state != IDLE).
- start while busy is ignored.
- wr_en while busy is ignored; buffer contents stay unchanged during a run.
- Widths:
  - rd_ptr is AW+1 bits, so a DEPTH-word frame compares without wrap.
  - frame_cnt is 8 bits; repeat_cnt=255 gives 256 frames.
- The memory read is combinational from the array into the registered output. No bubbles between words when rdy is held high.

## Timing
- Reset values: tap_out=0, tap_out_fst=0, tap_out_vld=0, busy=0, done=0; state=IDLE. Buffer contents are not reset.
- Start latency: start at cycle T gives busy=1 at T+1 and vld=1 with the first word at T+2.
- Throughput: 1 word/cycle with rdy constantly high.
- Frame boundary: no idle cycle. The fst word of frame k+1 follows the last word of frame k directly.
- Completion: last transfer at cycle T gives vld=0 and done=1 at T+1, busy=0 at T+2.
- len==0: start at T gives done=1 at T+2 with no vld ever asserted.
- Reset low mid-run: all outputs take their reset values at the next edge; no done pulse.
- A write and a start in the same IDLE cycle: the write completes, and the frame uses the new value.

## Configuration
- FLOAT_STREAM_TX_ABORT_EN defined: adds input abort (1 bit).
  - abort high in LOAD or RUN drops vld at the next edge and returns to IDLE.
  - busy=0 at that edge; no done pulse.
  - abort in IDLE or DONE has no effect.
- Macro undefined: no abort port; a run always completes.

## Test plan
- Single frame:
  - Stimulus: write mem[0..3]={1.0,2.0,3.0,4.0}; start with frame_len=4, repeat_cnt=0; rdy=1.
  - Response: 4 consecutive beats 1.0..4.0, fst only on 1.0; done one cycle after the last beat.
- Repeats with backpressure:
  - Stimulus: frame_len=3, repeat_cnt=2; rdy toggles 1,0,1,0.
  - Response: exactly 9 transfers with fst on transfers 1, 4 and 7; data stable whenever vld && !rdy.
- Boundary lengths:
  - frame_len=0: done at start+2, no vld.
  - frame_len=DEPTH+5: exactly 64 beats, clamped.
  - frame_len=DEPTH: all 64 addresses in order.
- Ignored inputs:
  - Stimulus: start again and wr_en to mem[0] mid-run.
  - Response: the run is unaffected; the next run still sends the old mem[0].
- Reset:
  - Stimulus: reset low for one cycle mid-frame.
  - Response: vld=0, busy=0, done=0 at the next edge; a new start works normally.
- Abort (FLOAT_STREAM_TX_ABORT_EN):
  - Stimulus: abort on the 5th beat of a 16-word frame.
  - Response: vld low next cycle, busy=0, no done pulse.
